// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_pkg
// Description : Shared pipeline definitions: controller state encoding, NOP
//               instruction word and register-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

  localparam int          c_REG_IDX_W = 5;
  localparam int          c_STATE_W   = 2;
  localparam logic [31:0] c_NOP_INSTR = 32'h00000013;

  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t S_RUN       = 2'd0;
  localparam state_t S_FLUSH     = 2'd1;
  localparam state_t S_DMEM_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_load_use_detect
// Description : Flags an ID instruction that reads the destination of a load
//               currently in EX (x0 never creates a dependency).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_load_use_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic                   ex_mem_read,
  input  logic [c_REG_IDX_W-1:0] ex_rd,
  input  logic [c_REG_IDX_W-1:0] id_rs1,
  input  logic [c_REG_IDX_W-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  output logic                   load_use
);

  logic w_rd_nonzero;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_rd_nonzero = (ex_rd != '0);
  assign w_hit_rs1    = id_uses_rs1 & (id_rs1 == ex_rd);
  assign w_hit_rs2    = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use     = ex_mem_read & w_rd_nonzero & (w_hit_rs1 | w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Hold/flush sequencer for the PC and the four pipeline
//               registers; handles dmem/imem waits, load-use and branch
//               redirects, and keeps saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [c_REG_IDX_W-1:0] id_rs1,
  input  logic [c_REG_IDX_W-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_mem_read,
  input  logic [c_REG_IDX_W-1:0] ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   imem_ready,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  output logic                   pc_load,
  output logic                   if_id_load,
  output logic                   if_id_flush,
  output logic                   id_ex_load,
  output logic                   id_ex_flush,
  output logic                   ex_mem_load,
  output logic                   mem_wb_load,
  output logic                   mem_wb_flush,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_events
);

  // Countdown only needs to hold FLUSH_CYCLES-1.
  localparam int               c_CD_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_CD_W-1:0] c_CD_INIT = c_CD_W'(FLUSH_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CD_W-1:0]  r_countdown;
  logic [c_CD_W-1:0]  w_countdown_next;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_events;
  logic               w_dmem_stall;
  logic               w_load_use;
  logic               w_branch_accept;

  assign w_dmem_stall = mem_access & ~dmem_ready;

  // In S_FLUSH, EX holds a bubble, so a branch indication there is ignored.
  assign w_branch_accept = ~reset & ~w_dmem_stall & (r_state != S_FLUSH) & ex_branch_taken;

  hazard_load_use_detect u_load_use (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (w_load_use)
  );

  // State and flush countdown registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_countdown <= '0;
    end else begin
      r_state     <= w_state_next;
      r_countdown <= w_countdown_next;
    end
  end

  // Next state: a dmem stall freezes everything; a released dmem wait
  // behaves like S_RUN and resumes an interrupted flush if one was pending.
  always_comb begin
    w_state_next     = r_state;
    w_countdown_next = r_countdown;
    if (w_dmem_stall) begin
      w_state_next = S_DMEM_WAIT;
    end else if (r_state == S_FLUSH) begin
      if (imem_ready) begin
        if (r_countdown != '0) begin
          w_countdown_next = r_countdown - 1'b1;
        end
        if (r_countdown <= c_CD_W'(1)) begin
          w_state_next = S_RUN;
        end
      end
    end else if (ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        w_countdown_next = c_CD_INIT;
        w_state_next     = S_FLUSH;
      end else begin
        w_state_next = S_RUN;
      end
    end else if (r_state == S_DMEM_WAIT) begin
      w_state_next = (r_countdown != '0) ? S_FLUSH : S_RUN;
    end else begin
      w_state_next = S_RUN;
    end
  end

  // Per-stage controls in priority order: reset, dmem stall, flush/branch,
  // load-use, imem wait, free run.
  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      pc_load = 1'b0;
    end else if (w_dmem_stall) begin
      mem_wb_load  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (r_state == S_FLUSH) begin
      pc_load     = imem_ready;
      if_id_load  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else if (ex_branch_taken) begin
      pc_load     = 1'b1;
      if_id_load  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else if (w_load_use) begin
      id_ex_load  = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else if (!imem_ready) begin
      // IF/ID is held and cleared so no stale fetch word advances.
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else begin
      pc_load     = 1'b1;
      if_id_load  = 1'b1;
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!pc_load && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_branch_accept && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller
//               with an expectation queue and a counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       imem_ready, mem_access, dmem_ready;
  logic       pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
  logic       ex_mem_load, mem_wb_load, mem_wb_flush;
  logic [3:0] stall_cycles, flush_events;
  logic [7:0] obs_ctrl;

  // Control vector order: pc, if_id_load, if_id_flush, id_ex_load,
  // id_ex_flush, ex_mem_load, mem_wb_load, mem_wb_flush.
  localparam logic [7:0] c_RST = 8'b0000_0000;
  localparam logic [7:0] c_RUN = 8'b1101_0110;
  localparam logic [7:0] c_LU  = 8'b0001_1110;
  localparam logic [7:0] c_BR  = 8'b1111_1110;
  localparam logic [7:0] c_FL  = 8'b1111_0110;
  localparam logic [7:0] c_FLW = 8'b0111_0110;
  localparam logic [7:0] c_IMW = 8'b0011_0110;
  localparam logic [7:0] c_DS  = 8'b0000_0011;

  typedef struct {
    string      tag;
    logic [7:0] ctrl;
    logic [3:0] st;
    logic [3:0] fe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] m_stall = '0;
  logic [3:0] m_flush = '0;

  assign obs_ctrl = {pc_load, if_id_load, if_id_flush, id_ex_load,
                     id_ex_flush, ex_mem_load, mem_wb_load, mem_wb_flush};

  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .pc_load         (pc_load),
    .if_id_load      (if_id_load),
    .if_id_flush     (if_id_flush),
    .id_ex_load      (id_ex_load),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_load     (ex_mem_load),
    .mem_wb_load     (mem_wb_load),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  // Inputs are already applied; queue the expectation, compare at the
  // negedge, then advance past the posedge and update the counter model.
  task automatic step(input string tag, input logic [7:0] ctrl, input bit br_acc);
    exp_t e, g;
    e.tag = tag; e.ctrl = ctrl; e.st = m_stall; e.fe = m_flush;
    q.push_back(e);
    @(negedge clock);
    g = q.pop_front();
    checks++;
    assert (obs_ctrl === g.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed %b expected %b", g.tag, obs_ctrl, g.ctrl);
    end
    checks++;
    assert (stall_cycles === g.st) else begin
      errors++;
      $error("FAIL %s stall_cycles observed %0d expected %0d", g.tag, stall_cycles, g.st);
    end
    checks++;
    assert (flush_events === g.fe) else begin
      errors++;
      $error("FAIL %s flush_events observed %0d expected %0d", g.tag, flush_events, g.fe);
    end
    @(posedge clock);
    if (reset) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ctrl[7] && m_stall != 4'hF) m_stall = m_stall + 1'b1;
      if (br_acc && m_flush != 4'hF) m_flush = m_flush + 1'b1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step("rst0", c_RST, 0);
    step("rst1", c_RST, 0);
    reset = 1'b0;
    step("idle", c_RUN, 0);

    // Load-use on rs2, then the same pattern against x0.
    set_load_use(5'd5);
    step("load_use", c_LU, 0);
    idle_inputs();
    step("lu_after", c_RUN, 0);
    set_load_use(5'd0);
    step("lu_x0", c_RUN, 0);
    idle_inputs();

    // Branch with a fetch wait stretching the flush window.
    ex_branch_taken = 1'b1;
    step("br_c0", c_BR, 1);
    ex_branch_taken = 1'b0; imem_ready = 1'b0;
    step("fl_wait", c_FLW, 0);
    imem_ready = 1'b1;
    step("fl_c1", c_FL, 0);
    step("br_done", c_RUN, 0);

    // Three-cycle data-memory stall, then release.
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("dmem_stall", c_DS, 0);
    dmem_ready = 1'b1;
    step("dmem_rel", c_RUN, 0);
    idle_inputs();
    step("dmem_done", c_RUN, 0);

    // Branch beats a simultaneous load-use.
    set_load_use(5'd5); ex_branch_taken = 1'b1;
    step("br_lu", c_BR, 1);
    idle_inputs();
    step("br_lu_fl", c_FL, 0);
    step("br_lu_done", c_RUN, 0);

    // Branch held off by a dmem stall, redirect on release.
    mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    step("br_ds0", c_DS, 0);
    step("br_ds1", c_DS, 0);
    dmem_ready = 1'b1;
    step("br_ds_rel", c_BR, 1);
    idle_inputs();
    step("br_ds_fl", c_FL, 0);
    step("br_ds_done", c_RUN, 0);

    // Load-use wins over a simultaneous fetch wait.
    set_load_use(5'd5); imem_ready = 1'b0;
    step("lu_imw", c_LU, 0);
    idle_inputs();

    // Reset in the middle of a flush window.
    ex_branch_taken = 1'b1;
    step("br_pre_rst", c_BR, 1);
    idle_inputs(); reset = 1'b1;
    step("rst_mid", c_RST, 0);
    reset = 1'b0;
    step("post_rst", c_RUN, 0);

    // Twenty fetch-wait cycles drive the 4-bit stall counter to saturation.
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step("imem_wait", c_IMW, 0);
    imem_ready = 1'b1;
    step("sat", c_RUN, 0);
    step("sat_hold", c_RUN, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
